// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// State encoding and default bus widths.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 15;
  localparam int FETCH_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one read at a time, buffers the word
// for decode, and squashes in-flight reads on a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = branch_valid ? branch_target : pc_in;
      end
      REQ: begin
        if (mem_ack && branch_valid) begin
          addr_d  = branch_target;
          valid_d = 1'b0;
        end else if (mem_ack) begin
          state_d = HOLD;
          instr_d = mem_rdata;
          ipc_d   = addr_q;
          valid_d = 1'b1;
        end else if (branch_valid) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (branch_valid) begin
          state_d = REQ;
          addr_d  = branch_target;
          valid_d = 1'b0;
        end else if (instr_ready) begin
          state_d = REQ;
          addr_d  = pc_in;
          valid_d = 1'b0;
        end
      end
      DROP: begin
        // the arriving word belongs to the old path
        if (mem_ack) begin
          state_d = REQ;
          addr_d  = branch_valid ? branch_target : pc_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ipc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign mem_req      = (state_q == REQ) || (state_q == DROP);
  assign mem_addr     = addr_q;
  assign instr_valid  = valid_q;
  assign instr        = instr_q;
  assign instr_pc     = ipc_q;
  assign pc_load      = reset_n & branch_valid;
  assign pc_load_addr = branch_target;
  assign pc_inc       = reset_n & (state_q == REQ)
                      & mem_ack & ~branch_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC model beside it and
// a queue of expected fetched words.
module tb_fetch_unit;

  localparam int AW = 15;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] pc_in;
  logic          pc_inc;
  logic          pc_load;
  logic [AW-1:0] pc_load_addr;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   inc_cnt = 0;
  int   c0;

  fetch_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_in        (pc_in),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready)
  );

  always #5 clk = ~clk;

  // Program counter that sits beside fetch_unit
  always @(posedge clk) begin
    if (!reset_n) pc_in <= '0;
    else if (pc_load) pc_in <= pc_load_addr;
    else if (pc_inc) pc_in <= pc_in + 1'b1;
  end

  always @(posedge clk) if (pc_inc) inc_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ack_word(input logic [DW-1:0] d,
                          input logic [AW-1:0] a);
    mem_ack   = 1'b1;
    mem_rdata = d;
    sb.push_back({d, a});
  endtask

  task automatic expect_instr(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(instr_valid), 1);
      chk({tag, "_instr"}, 32'(instr), 32'(e.data));
      chk({tag, "_pc"}, 32'(instr_pc), 32'(e.pc));
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 15'h7fff;
    mem_ack       = 1'b1;
    mem_rdata     = 16'h5a5a;
    instr_ready   = 1'b0;
    tick();
    chk("rst_pc_load", 32'(pc_load), 0);
    chk("rst_pc_inc", 32'(pc_inc), 0);
    tick();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_ipc", 32'(instr_pc), 0);

    reset_n      = 1'b1;
    branch_valid = 1'b0;
    mem_ack      = 1'b0;
    tick();
    chk("first_req", 32'(mem_req), 1);
    chk("first_addr", 32'(mem_addr), 0);
    chk("first_valid", 32'(instr_valid), 0);
    ack_word(16'habcd, 15'h0);
    settle();
    chk("first_inc", 32'(pc_inc), 1);
    tick();
    mem_ack = 1'b0;
    expect_instr("first");
    chk("hold_req", 32'(mem_req), 0);
    chk("inc_once", 32'(inc_cnt), 1);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", 32'(instr), 32'h abcd);
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_req", 32'(mem_req), 0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("next_req", 32'(mem_req), 1);
    chk("next_addr", 32'(mem_addr), 1);
    chk("next_valid", 32'(instr_valid), 0);
    ack_word(16'h1234, 15'h1);
    tick();
    mem_ack = 1'b0;
    expect_instr("second");

    branch_valid  = 1'b1;
    branch_target = 15'h0100;
    instr_ready   = 1'b1;
    settle();
    chk("hbr_load", 32'(pc_load), 1);
    chk("hbr_laddr", 32'(pc_load_addr), 32'h0100);
    chk("hbr_inc", 32'(pc_inc), 0);
    tick();
    branch_valid = 1'b0;
    instr_ready  = 1'b0;
    chk("hbr_valid", 32'(instr_valid), 0);
    chk("hbr_req", 32'(mem_req), 1);
    chk("hbr_addr", 32'(mem_addr), 32'h0100);
    ack_word(16'h5555, 15'h0100);
    tick();
    mem_ack = 1'b0;
    expect_instr("after_hbr");
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("seq_addr", 32'(mem_addr), 32'h0101);

    c0            = inc_cnt;
    branch_valid  = 1'b1;
    branch_target = 15'h0200;
    settle();
    chk("rbr_load", 32'(pc_load), 1);
    chk("rbr_inc", 32'(pc_inc), 0);
    tick();
    branch_valid = 1'b0;
    chk("drop_addr0", 32'(mem_addr), 32'h0101);
    chk("drop_req0", 32'(mem_req), 1);
    chk("drop_valid0", 32'(instr_valid), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("drop_addr", 32'(mem_addr), 32'h0101);
      chk("drop_req", 32'(mem_req), 1);
      chk("drop_valid", 32'(instr_valid), 0);
    end
    mem_ack   = 1'b1;
    mem_rdata = 16'hdead;
    settle();
    chk("drop_inc", 32'(pc_inc), 0);
    tick();
    mem_ack = 1'b0;
    chk("redir_addr", 32'(mem_addr), 32'h0200);
    chk("redir_valid", 32'(instr_valid), 0);
    chk("redir_req", 32'(mem_req), 1);
    chk("redir_noinc", 32'(inc_cnt), 32'(c0));
    ack_word(16'h7777, 15'h0200);
    tick();
    mem_ack = 1'b0;
    expect_instr("after_drop");
    chk("inc_after_drop", 32'(inc_cnt), 32'(c0 + 1));
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("seq_addr2", 32'(mem_addr), 32'h0201);

    branch_valid  = 1'b1;
    branch_target = 15'h0400;
    tick();
    branch_target = 15'h0300;
    settle();
    chk("dbr_load", 32'(pc_load), 1);
    chk("dbr_laddr", 32'(pc_load_addr), 32'h0300);
    tick();
    branch_valid = 1'b0;
    chk("dbr_req", 32'(mem_req), 1);
    chk("dbr_addr", 32'(mem_addr), 32'h0201);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("dbr_final", 32'(mem_addr), 32'h0300);
    chk("dbr_valid", 32'(instr_valid), 0);

    branch_valid  = 1'b1;
    branch_target = 15'h0500;
    mem_ack       = 1'b1;
    mem_rdata     = 16'hbeef;
    settle();
    chk("abr_inc", 32'(pc_inc), 0);
    tick();
    branch_valid = 1'b0;
    mem_ack      = 1'b0;
    chk("abr_addr", 32'(mem_addr), 32'h0500);
    chk("abr_valid", 32'(instr_valid), 0);
    chk("abr_req", 32'(mem_req), 1);

    branch_valid  = 1'b1;
    branch_target = 15'h0600;
    tick();
    branch_target = 15'h0700;
    mem_ack       = 1'b1;
    tick();
    branch_valid = 1'b0;
    mem_ack      = 1'b0;
    chk("dack_addr", 32'(mem_addr), 32'h0700);
    chk("dack_valid", 32'(instr_valid), 0);

    reset_n = 1'b0;
    tick();
    chk("mrst_req", 32'(mem_req), 0);
    chk("mrst_valid", 32'(instr_valid), 0);
    chk("mrst_addr", 32'(mem_addr), 0);
    reset_n   = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    settle();
    chk("late_inc", 32'(pc_inc), 0);
    tick();
    mem_ack = 1'b0;
    chk("late_valid", 32'(instr_valid), 0);
    chk("late_req", 32'(mem_req), 1);
    chk("late_addr", 32'(mem_addr), 0);
    tick();
    chk("late_valid2", 32'(instr_valid), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
